// File: rtl/reg_file_ctrl_pkg.sv
// Shared types and sizing for the register-file access controller.
// Holds the controller state encoding and the register file geometry.
package reg_file_ctrl_pkg;

    localparam int REG_CNT = 16;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_CNT - 1);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        DBG  = 2'd2,
        ACK  = 2'd3
    } state_e;

    // True when the clear sequence is writing its final register.
    function automatic logic is_last_addr(input logic [ADDR_W-1:0] addr);
        return (addr == LAST_ADDR);
    endfunction

endpackage

// File: rtl/reg_file_ctrl.sv
// Arbitrates the register file write/X-read port between the CPU and a debug port,
// and clears every register after reset before handing the port to the CPU.
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr_x,
    input  logic              cpu_write_en,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wr_data,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rd_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] rf_addr_x,
    output logic              rf_write_en,
    output logic [DATA_W-1:0] rf_wr_data,
    input  logic [DATA_W-1:0] rf_rd_data_x
);

    state_e              state_r;
    logic [ADDR_W-1:0]   clr_cnt_r;
    logic                init_done_r;
    logic                dbg_ack_r;
    logic [DATA_W-1:0]   dbg_rd_data_r;

    // Port steering: reset and INIT own the port for clearing, DBG borrows it for one cycle.
    always_comb begin
        cpu_stall   = 1'b0;
        rf_addr_x   = cpu_addr_x;
        rf_write_en = cpu_write_en;
        rf_wr_data  = cpu_wr_data;
        if (rst) begin
            // Held reset keeps clearing register 0 rather than leaving the port to the CPU.
            cpu_stall   = 1'b1;
            rf_addr_x   = {ADDR_W{1'b0}};
            rf_write_en = 1'b1;
            rf_wr_data  = {DATA_W{1'b0}};
        end else begin
            case (state_r)
                INIT: begin
                    cpu_stall   = 1'b1;
                    rf_addr_x   = clr_cnt_r;
                    rf_write_en = 1'b1;
                    rf_wr_data  = {DATA_W{1'b0}};
                end
                DBG: begin
                    cpu_stall   = 1'b1;
                    rf_addr_x   = dbg_addr;
                    rf_write_en = dbg_we;
                    rf_wr_data  = dbg_wr_data;
                end
                IDLE, ACK: begin
                    cpu_stall   = 1'b0;
                    rf_addr_x   = cpu_addr_x;
                    rf_write_en = cpu_write_en;
                    rf_wr_data  = cpu_wr_data;
                end
                default: begin
                    cpu_stall   = 1'b1;
                    rf_addr_x   = cpu_addr_x;
                    rf_write_en = 1'b0;
                    rf_wr_data  = cpu_wr_data;
                end
            endcase
        end
    end

    // Controller state, clear counter and registered debug/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= INIT;
            clr_cnt_r     <= {ADDR_W{1'b0}};
            init_done_r   <= 1'b0;
            dbg_ack_r     <= 1'b0;
            dbg_rd_data_r <= {DATA_W{1'b0}};
        end else begin
            dbg_ack_r <= 1'b0;
            case (state_r)
                INIT: begin
                    clr_cnt_r <= clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (is_last_addr(clr_cnt_r)) begin
                        state_r     <= IDLE;
                        init_done_r <= 1'b1;
                    end else begin
                        state_r     <= INIT;
                        init_done_r <= 1'b0;
                    end
                end
                IDLE: begin
                    if (dbg_req) begin
                        state_r <= DBG;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DBG: begin
                    // Read data is sampled before the write lands, so a debug write returns the old value.
                    dbg_rd_data_r <= rf_rd_data_x;
                    dbg_ack_r     <= 1'b1;
                    state_r       <= ACK;
                end
                ACK: begin
                    // A request still held here is deliberately ignored to avoid a double service.
                    state_r <= IDLE;
                end
                default: begin
                    state_r     <= INIT;
                    clr_cnt_r   <= {ADDR_W{1'b0}};
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_ack     = dbg_ack_r;
    assign dbg_rd_data = dbg_rd_data_r;
    assign init_done   = init_done_r;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed bench for reg_file_ctrl with a cycle-timed reference model and
// a bench-side register file feeding the X read port.
module tb_reg_file_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cpu_addr_x = 4'd0;
    logic       cpu_write_en = 1'b0;
    logic [7:0] cpu_wr_data = 8'h00;
    logic       cpu_stall;
    logic       dbg_req = 1'b0;
    logic       dbg_we = 1'b0;
    logic [3:0] dbg_addr = 4'd0;
    logic [7:0] dbg_wr_data = 8'h00;
    logic       dbg_ack;
    logic [7:0] dbg_rd_data;
    logic       init_done;
    logic [3:0] rf_addr_x;
    logic       rf_write_en;
    logic [7:0] rf_wr_data;
    logic [7:0] rf_rd_data_x;

    reg_file_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr_x   (cpu_addr_x),
        .cpu_write_en (cpu_write_en),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_stall    (cpu_stall),
        .dbg_req      (dbg_req),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_wr_data  (dbg_wr_data),
        .dbg_ack      (dbg_ack),
        .dbg_rd_data  (dbg_rd_data),
        .init_done    (init_done),
        .rf_addr_x    (rf_addr_x),
        .rf_write_en  (rf_write_en),
        .rf_wr_data   (rf_wr_data),
        .rf_rd_data_x (rf_rd_data_x)
    );

    always #5 clk = ~clk;

    // Environment register file driven by the DUT's port.
    logic [7:0] tb_rf [16] = '{default: 8'h00};
    always @(posedge clk) begin
        if (rf_write_en) tb_rf[rf_addr_x] <= rf_wr_data;
    end
    assign rf_rd_data_x = tb_rf[rf_addr_x];

    // Reference model: time since reset, cycle number of the granted debug slot, expected register contents.
    int         cyc     = 0;
    int         m_k     = 0;
    int         m_dbg   = -100;
    logic       m_valid = 1'b0;
    logic [7:0] m_rd    = 8'h00;
    logic [7:0] m_mem [16] = '{default: 8'h00};

    function automatic logic e_clear();
        return rst || (m_k < 16);
    endfunction
    function automatic logic e_dbg();
        return !e_clear() && (cyc == m_dbg);
    endfunction
    function automatic logic e_stall();
        return e_clear() || e_dbg();
    endfunction
    function automatic logic [3:0] e_addr();
        if (rst) return 4'd0;
        if (m_k < 16) return 4'(m_k);
        if (e_dbg()) return dbg_addr;
        return cpu_addr_x;
    endfunction
    function automatic logic e_we();
        if (e_clear()) return 1'b1;
        if (e_dbg()) return dbg_we;
        return cpu_write_en;
    endfunction
    function automatic logic [7:0] e_data();
        if (e_clear()) return 8'h00;
        if (e_dbg()) return dbg_wr_data;
        return cpu_wr_data;
    endfunction

    always @(posedge clk) begin
        if (m_valid && e_we()) m_mem[e_addr()] <= e_data();
        if (m_valid && e_dbg()) m_rd <= m_mem[e_addr()];
        if (rst) begin
            m_k     <= 0;
            m_dbg   <= -100;
            m_rd    <= 8'h00;
            m_valid <= 1'b1;
        end else begin
            if (m_k < 16) m_k <= m_k + 1;
            if (m_valid && m_k >= 16 && cyc != m_dbg && cyc != m_dbg + 1 && dbg_req)
                m_dbg <= cyc + 1;
        end
        cyc <= cyc + 1;
    end

    // Hand-computed pins, consumed by the compare process at the next falling edge.
    typedef struct {
        string      nm;
        int         sig;
        int         idx;
        logic [7:0] val;
    } pin_t;
    pin_t pin_q[$];
    int   pin_rd = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic pin(input string nm, input int sig, input int idx, input logic [7:0] val);
        pin_t p;
        p.nm = nm; p.sig = sig; p.idx = idx; p.val = val;
        pin_q.push_back(p);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin : compare
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("cpu_stall",   {7'd0, cpu_stall},   {7'd0, e_stall()});
                chk("rf_addr_x",   {4'd0, rf_addr_x},   {4'd0, e_addr()});
                chk("rf_write_en", {7'd0, rf_write_en}, {7'd0, e_we()});
                chk("rf_wr_data",  rf_wr_data,          e_data());
                chk("init_done",   {7'd0, init_done},   {7'd0, (m_k >= 16)});
                chk("dbg_ack",     {7'd0, dbg_ack},     {7'd0, (cyc == m_dbg + 1)});
                chk("dbg_rd_data", dbg_rd_data,         m_rd);
            end
            while (pin_rd < pin_q.size()) begin
                case (pin_q[pin_rd].sig)
                    0:       act = dbg_rd_data;
                    1:       act = rf_wr_data;
                    2:       act = {4'd0, rf_addr_x};
                    3:       act = {7'd0, cpu_stall};
                    4:       act = {7'd0, dbg_ack};
                    5:       act = {7'd0, init_done};
                    6:       act = {7'd0, rf_write_en};
                    default: act = tb_rf[pin_q[pin_rd].idx];
                endcase
                chk(pin_q[pin_rd].nm, act, pin_q[pin_rd].val);
                pin_rd++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_set(input logic req, input logic we, input logic [3:0] a, input logic [7:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wr_data = d;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        pin("clear_first_addr", 2, 0, 8'h00);
        pin("clear_stall", 3, 0, 8'h01);
        pin("init_done_low", 5, 0, 8'h00);
        repeat (15) tick();
        pin("clear_last_addr", 2, 0, 8'h0F);
        pin("clear_last_we", 6, 0, 8'h01);
        tick();
        pin("init_done_high", 5, 0, 8'h01);
        pin("idle_no_stall", 3, 0, 8'h00);

        // Debug write r5 = A7, then read it back.
        dbg_set(1'b1, 1'b1, 4'd5, 8'hA7);
        tick();
        pin("dbg_wr_stall", 3, 0, 8'h01);
        pin("dbg_wr_data", 1, 0, 8'hA7);
        tick();
        pin("dbg_wr_ack", 4, 0, 8'h01);
        dbg_set(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        pin("ack_one_cycle", 4, 0, 8'h00);
        dbg_set(1'b1, 1'b0, 4'd5, 8'h00);
        tick();
        tick();
        pin("dbg_rd_r5", 0, 0, 8'hA7);
        dbg_set(1'b0, 1'b0, 4'd0, 8'h00);
        tick();

        // CPU writes r3 = 11 while a debug write r3 = 22 arrives.
        cpu_write_en = 1'b1; cpu_addr_x = 4'd3; cpu_wr_data = 8'h11;
        dbg_set(1'b1, 1'b1, 4'd3, 8'h22);
        tick();
        pin("dbg_overrides_cpu", 1, 0, 8'h22);
        pin("dbg_addr_r3", 2, 0, 8'h03);
        tick();
        pin("cpu_resumes_data", 1, 0, 8'h11);
        pin("cpu_resumes_stall", 3, 0, 8'h00);
        dbg_set(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        cpu_write_en = 1'b0;
        pin("rf_r3_cpu", 7, 3, 8'h11);
        dbg_set(1'b1, 1'b0, 4'd3, 8'h00);
        tick();
        tick();
        pin("dbg_rd_r3", 0, 0, 8'h11);
        dbg_set(1'b0, 1'b0, 4'd0, 8'h00);
        tick();

        // A few CPU writes, then a debug read of one of them.
        for (int i = 0; i < 4; i++) begin
            cpu_write_en = 1'b1;
            cpu_addr_x   = 4'(8 + i);
            cpu_wr_data  = 8'(8'h30 + i);
            tick();
        end
        cpu_write_en = 1'b0;
        dbg_set(1'b1, 1'b0, 4'd9, 8'h00);
        tick();
        tick();
        pin("dbg_rd_r9", 0, 0, 8'h31);
        dbg_set(1'b0, 1'b0, 4'd0, 8'h00);
        tick();

        // Held request: one service every third cycle.
        dbg_set(1'b1, 1'b0, 4'd8, 8'h00);
        tick();
        tick();
        pin("held_ack1", 4, 0, 8'h01);
        tick();
        pin("held_no_double", 4, 0, 8'h00);
        tick();
        pin("held_dbg2_stall", 3, 0, 8'h01);
        tick();
        pin("held_ack2", 4, 0, 8'h01);
        pin("held_rd_r8", 0, 0, 8'h30);
        tick();
        tick();
        tick();
        pin("held_ack3", 4, 0, 8'h01);
        dbg_set(1'b0, 1'b0, 4'd0, 8'h00);
        tick();

        // Reset during DBG discards the access; a request raised during INIT waits for IDLE.
        dbg_set(1'b1, 1'b1, 4'd7, 8'h5A);
        tick();
        rst = 1'b1;
        tick();
        pin("rst_no_ack", 4, 0, 8'h00);
        pin("rst_rd_clear", 0, 0, 8'h00);
        pin("rst_init_low", 5, 0, 8'h00);
        rst = 1'b0;
        dbg_set(1'b1, 1'b0, 4'd9, 8'h00);
        repeat (15) tick();
        pin("reclear_last_addr", 2, 0, 8'h0F);
        pin("init_hold_stall", 3, 0, 8'h01);
        tick();
        pin("reinit_done", 5, 0, 8'h01);
        pin("rf_r3_cleared", 7, 3, 8'h00);
        pin("rf_r9_cleared", 7, 9, 8'h00);
        tick();
        pin("post_init_dbg_addr", 2, 0, 8'h09);
        tick();
        pin("post_init_ack", 4, 0, 8'h01);
        pin("post_init_rd_zero", 0, 0, 8'h00);
        dbg_set(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        tick();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_ctrl.md
REG_FILE_CTRL -- requirements
Module: reg_file_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 cpu_addr_x  input  4  CPU X/write register address.
REQ-005 cpu_write_en  input  1  CPU register write request.
REQ-006 cpu_wr_data  input  8  CPU write data.
REQ-007 cpu_stall  output  1  CPU SHALL hold its current instruction while high.
REQ-008 dbg_req  input  1  debug access request; held high until dbg_ack.
REQ-009 dbg_we  input  1  debug access is a write (1) or read (0); stable while dbg_req high.
REQ-010 dbg_addr  input  4  debug register address; stable while dbg_req high.
REQ-011 dbg_wr_data  input  8  debug write data; stable while dbg_req high.
REQ-012 dbg_ack  output  1  one-cycle completion pulse.
REQ-013 dbg_rd_data  output  8  registered register value captured by the last debug access.
REQ-014 init_done  output  1  high once the register-clear sequence has finished.
REQ-015 rf_addr_x  output  4  address to the register file write/X-read port.
REQ-016 rf_write_en  output  1  register file write enable.
REQ-017 rf_wr_data  output  8  register file write data.
REQ-018 rf_rd_data_x  input  8  register file X-port asynchronous read data.

Function
REQ-019 The FSM SHALL have the states INIT, IDLE, DBG and ACK.
REQ-020 INIT: a 4-bit counter SHALL drive rf_addr_x, with rf_write_en=1, rf_wr_data=0x00 and cpu_stall=1; it SHALL step 0..15, one register per cycle, and SHALL enter IDLE after address 15 is written (16 cycles).
REQ-021 init_done SHALL be 0 in INIT and 1 in all other states; it SHALL be registered.
REQ-022 IDLE: rf_addr_x=cpu_addr_x, rf_wr_data=cpu_wr_data, rf_write_en=cpu_write_en, cpu_stall=0.
REQ-023 IDLE with dbg_req=1 sampled at an edge SHALL move to DBG; the CPU access in that same IDLE cycle SHALL still complete.
REQ-024 DBG (exactly one cycle): cpu_stall=1, rf_addr_x=dbg_addr, rf_wr_data=dbg_wr_data, rf_write_en=dbg_we; cpu_write_en SHALL be ignored.
REQ-025 DBG SHALL capture rf_rd_data_x into dbg_rd_data at the end of the cycle; for a write this captures the pre-write value.
REQ-026 DBG SHALL always go to ACK; ACK SHALL drive dbg_ack=1 and behave as IDLE for the CPU path, then always go to IDLE.
REQ-027 dbg_req SHALL NOT be sampled in ACK, so a request still held during the ack cycle does not retrigger.
REQ-028 Latency: dbg_req rising before edge k SHALL give DBG in cycle k+1 and dbg_ack in cycle k+2. Back-to-back requests SHALL be serviced at most once per 3 cycles, with the CPU stalled 1 cycle in 3.
REQ-029 dbg_req=1 while in INIT SHALL be held off until IDLE.
REQ-030 cpu_stall and the rf_* outputs SHALL be combinational from state and inputs.
REQ-031 dbg_ack and dbg_rd_data SHALL be registered.

Reset
REQ-032 rst=1 at an edge SHALL force INIT with counter=0, init_done=0, dbg_ack=0 and dbg_rd_data=0x00, regardless of state.
REQ-033 An in-flight debug request SHALL be discarded with no ack; the requester re-issues it after init_done.
REQ-034 While rst is high, INIT outputs SHALL apply, so the register-0 clear repeats every cycle.

Structure
REQ-035 A shared package SHALL hold the state encoding (2-bit enum: INIT, IDLE, DBG, ACK), REG_CNT=16, ADDR_W=4 and DATA_W=8.
REQ-036 The block SHALL contain no sub-module; the register file is instantiated beside it by the CPU top level, and the Y read port is not routed through this block.

Verification
REQ-037 Reset then count cycles: 16 writes of 0x00 to addresses 0..15; init_done rises after the 16th; cpu_stall=1 throughout.
REQ-038 Debug write addr 5 data 0xA7 during idle: one DBG cycle with stall=1, dbg_ack 2 cycles after the request, then a debug read of 5 returns 0xA7.
REQ-039 CPU writes r3=0x11 every cycle while a debug write of r3=0x22 arrives: the DBG cycle writes 0x22, the CPU write in that cycle is suppressed, and the CPU resumes after the stall.
REQ-040 dbg_req held high continuously: acks every 3rd cycle; no double ack from a held request in ACK.
REQ-041 rst asserted during DBG: no dbg_ack; full 16-cycle clear restarts; dbg_rd_data=0x00.
REQ-042 dbg_req asserted during INIT: serviced in the first DBG after init_done; read of any register returns 0x00.
